// File: rtl/rle_bit_unpacker_pkg.sv
// Shared types and constants for the run-length bit unpacker.
// Holds the controller state encoding and the zero-run rule.
package rle_bit_unpacker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } rleState_t;

  // A run field of zero stands for the largest run, 2^RUN_W bits.
  localparam bit ZERO_RUN_IS_FULL = 1'b1;

endpackage

// File: rtl/rle_bit_unpacker_if.sv
// Token input and RAM write port of the unpacker, bundled as one interface.
// Both sides are valid/ready: a transfer happens on a rising edge where valid (tok_valid / mem_wr) and ready (tok_ready / mem_ready) are both high; the source holds its payload stable until then.
interface rle_bit_unpacker_if #(
  parameter int ADDR_W = 16,
  parameter int RUN_W  = 8
);
  logic              tok_valid;
  logic              tok_ready;
  logic              tok_bit;
  logic [RUN_W-1:0]  tok_run;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ready;

  modport master (
    output tok_valid, tok_bit, tok_run, mem_ready,
    input  tok_ready, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  tok_valid, tok_bit, tok_run, mem_ready,
    output tok_ready, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rle_bit_unpacker_fill_mask.sv
// Sets n bits of the partial byte, from position bitIdx downward, to value b.
// Flags when the lowest written bit is bit 0, i.e. the byte is full.
module rle_fill_mask (
  input  logic [2:0] bitIdx,
  input  logic [3:0] n,
  input  logic       b,
  input  logic [7:0] partial,
  output logic [7:0] newPartial,
  output logic       byteComplete
);
  logic [3:0] bitsLeft;
  logic [3:0] lowBit;
  logic [8:0] upper;
  logic [8:0] lower;
  logic [7:0] mask;

  assign bitsLeft     = {1'b0, bitIdx} + 4'd1;
  assign lowBit       = bitsLeft - n;
  assign upper        = (9'd1 << bitsLeft) - 9'd1;
  assign lower        = (9'd1 << lowBit) - 9'd1;
  assign mask         = upper[7:0] & ~lower[7:0];
  assign newPartial   = b ? (partial | mask) : (partial & ~mask);
  assign byteComplete = (lowBit == 4'd0);
endmodule

// File: rtl/rle_bit_unpacker.sv
// Expands run-length tokens into an MSB-first bitstream and writes it to RAM
// one byte at a time; a flush writes out any partially filled byte.
module rle_bit_unpacker
  import rle_bit_unpacker_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RUN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              flush,
  rle_bit_unpacker_if.slave bus,
  output logic [ADDR_W-1:0] byte_idx,
  output logic [2:0]        bit_idx,
  output logic              busy,
  output logic              done,
  output rleState_t         dbgState
);
  localparam logic [RUN_W:0] FULL_RUN = {1'b1, {RUN_W{1'b0}}};

  rleState_t      state;
  logic [RUN_W:0] rem;
  logic           runBit;
  logic [7:0]     partial;
  logic [3:0]     bitsLeft;
  logic [3:0]     fillN;
  logic [7:0]     filled;
  logic           byteComplete;
  logic           tokFire;

  // start and flush outrank a token, so the token is held off while either is up.
  assign bus.tok_ready = (state == IDLE) && !flush && !start;
  assign tokFire       = bus.tok_valid && bus.tok_ready;
  assign busy          = (state != IDLE);
  assign dbgState      = state;

  assign bitsLeft = {1'b0, bit_idx} + 4'd1;
  assign fillN    = (rem < (RUN_W+1)'(bitsLeft)) ? rem[3:0] : bitsLeft;

  rle_fill_mask u_fill (
    .bitIdx      (bit_idx),
    .n           (fillN),
    .b           (runBit),
    .partial     (partial),
    .newPartial  (filled),
    .byteComplete(byteComplete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_idx      <= '0;
      bit_idx       <= 3'd7;
      partial       <= 8'h00;
      rem           <= '0;
      runBit        <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 8'h00;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            byte_idx <= start_addr;
            bit_idx  <= 3'd7;
            partial  <= 8'h00;
          end else if (flush) begin
            state <= FLUSH;
          end else if (tokFire) begin
            rem    <= (bus.tok_run == '0 && ZERO_RUN_IS_FULL) ? FULL_RUN : {1'b0, bus.tok_run};
            runBit <= bus.tok_bit;
            state  <= RUN;
          end
        end
        RUN: begin
          partial <= filled;
          rem     <= rem - (RUN_W+1)'(fillN);
          if (byteComplete) begin
            bus.mem_wr    <= 1'b1;
            bus.mem_addr  <= byte_idx;
            bus.mem_wdata <= filled;
            state         <= WRITE;
          end else begin
            // Run ended inside the byte: keep the partial byte for the next token.
            bit_idx <= bit_idx - fillN[2:0];
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            bus.mem_wr <= 1'b0;
            byte_idx   <= byte_idx + ADDR_W'(1);
            bit_idx    <= 3'd7;
            partial    <= 8'h00;
            if (rem != '0) begin
              state <= RUN;
            end else begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (bit_idx == 3'd7) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            // rem is zero here, so WRITE finishes straight back to IDLE.
            bus.mem_wr    <= 1'b1;
            bus.mem_addr  <= byte_idx;
            bus.mem_wdata <= partial;
            state         <= WRITE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rle_bit_unpacker.sv
// Directed bench for rle_bit_unpacker: token runs, flushes, write stalls,
// reset mid-run and address wrap, with a scoreboard of expected RAM writes.
module tb_rle_bit_unpacker;
  import rle_bit_unpacker_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] byte_idx;
  logic [2:0]  bit_idx;
  logic        busy;
  logic        done;
  rleState_t   dbg_state;

  int          n_compared = 0;
  int          n_mismatched = 0;
  int          wr_count = 0;
  int          done_cnt = 0;
  logic [31:0] mon_exp;
  logic [23:0] exp_q[$];

  rle_bit_unpacker_if #(.ADDR_W(16), .RUN_W(8)) bus ();

  rle_bit_unpacker #(.ADDR_W(16), .RUN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .flush     (flush),
    .bus       (bus),
    .byte_idx  (byte_idx),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .done      (done),
    .dbgState  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor: every accepted write must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_wr === 1'b1 && bus.mem_ready === 1'b1) begin
        wr_count++;
        mon_exp = (exp_q.size() > 0) ? {8'h00, exp_q.pop_front()} : 32'hFFFF_FFFF;
        check_val("wr", {8'h00, bus.mem_addr, bus.mem_wdata}, mon_exp);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // driver tasks
  task automatic expect_wr(input logic [15:0] addr, input logic [7:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic do_start(input logic [15:0] addr);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = addr;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic send_token(input logic b, input logic [7:0] run);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    bus.tok_valid = 1'b1;
    bus.tok_bit = b;
    bus.tok_run = run;
    @(negedge clk);
    while (bus.tok_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_val("tok_accept", {31'd0, bus.tok_ready}, 32'd1);
    @(posedge clk); #1;
    bus.tok_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int waited;
    waited = 0;
    while (done_cnt <= base && waited < 3000) begin
      @(negedge clk); #1;
      waited++;
    end
    check_val(tag, {31'd0, done_cnt > base}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wr"}, {31'd0, bus.mem_wr}, 32'd0);
    check_val({tag, "_addr"}, {16'd0, bus.mem_addr}, 32'd0);
    check_val({tag, "_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
    check_val({tag, "_byte_idx"}, {16'd0, byte_idx}, 32'd0);
    check_val({tag, "_bit_idx"}, {29'd0, bit_idx}, 32'd7);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_done"}, {31'd0, done}, 32'd0);
    check_val({tag, "_tok_ready"}, {31'd0, bus.tok_ready}, 32'd1);
    check_val({tag, "_state"}, {30'd0, dbg_state}, {30'd0, IDLE});
  endtask

  initial begin
    int base;
    int wb;
    int waited;
    bus.tok_valid = 1'b0;
    bus.tok_bit = 1'b0;
    bus.tok_run = '0;
    bus.mem_ready = 1'b1;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // 1: (1,3) then (0,5) -> 0xE0 @0x0010
    base = done_cnt;
    do_start(16'h0010);
    expect_wr(16'h0010, 8'hE0);
    send_token(1'b1, 8'd3);
    wait_done(base, "t1_done_a");
    check_val("t1_bit_idx_mid", {29'd0, bit_idx}, 32'd4);
    check_val("t1_byte_idx_mid", {16'd0, byte_idx}, 32'h0010);
    send_token(1'b0, 8'd5);
    wait_done(base + 1, "t1_done_b");
    idle_cycles(3);
    check_val("t1_byte_idx", {16'd0, byte_idx}, 32'h0011);
    check_val("t1_bit_idx", {29'd0, bit_idx}, 32'd7);
    check_val("t1_done_count", done_cnt - base, 32'd2);
    check_val("t1_pending", exp_q.size(), 32'd0);

    // 2: (1,12) then flush, then a flush with nothing held
    base = done_cnt;
    do_start(16'h0000);
    expect_wr(16'h0000, 8'hFF);
    send_token(1'b1, 8'd12);
    wait_done(base, "t2_done_tok");
    check_val("t2_byte_idx_mid", {16'd0, byte_idx}, 32'd1);
    check_val("t2_bit_idx_mid", {29'd0, bit_idx}, 32'd3);
    expect_wr(16'h0001, 8'hF0);
    do_flush();
    wait_done(base + 1, "t2_done_flush");
    check_val("t2_byte_idx", {16'd0, byte_idx}, 32'd2);
    check_val("t2_bit_idx", {29'd0, bit_idx}, 32'd7);
    check_val("t2_pending", exp_q.size(), 32'd0);
    wb = wr_count;
    do_flush();
    wait_done(base + 2, "t2_done_empty_flush");
    idle_cycles(3);
    check_val("t2_empty_flush_writes", wr_count - wb, 32'd0);
    check_val("t2_empty_flush_byte_idx", {16'd0, byte_idx}, 32'd2);

    // 3: (0,0) -> 256 zero bits, 32 writes
    base = done_cnt;
    wb = wr_count;
    do_start(16'h0000);
    for (int i = 0; i < 32; i++) expect_wr(16'(i), 8'h00);
    send_token(1'b0, 8'd0);
    wait_done(base, "t3_done");
    idle_cycles(3);
    check_val("t3_byte_idx", {16'd0, byte_idx}, 32'd32);
    check_val("t3_bit_idx", {29'd0, bit_idx}, 32'd7);
    check_val("t3_writes", wr_count - wb, 32'd32);
    check_val("t3_done_count", done_cnt - base, 32'd1);
    check_val("t3_pending", exp_q.size(), 32'd0);

    // 4: write stalled by mem_ready low for 5 cycles
    base = done_cnt;
    bus.mem_ready = 1'b0;
    do_start(16'h0020);
    wb = wr_count;
    send_token(1'b1, 8'd8);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("t4_stall_wr", {31'd0, bus.mem_wr}, 32'd1);
      check_val("t4_stall_addr", {16'd0, bus.mem_addr}, 32'h0020);
      check_val("t4_stall_wdata", {24'd0, bus.mem_wdata}, 32'hFF);
      check_val("t4_stall_tok_ready", {31'd0, bus.tok_ready}, 32'd0);
    end
    check_val("t4_stall_writes", wr_count - wb, 32'd0);
    check_val("t4_stall_state", {30'd0, dbg_state}, {30'd0, WRITE});
    @(posedge clk); #1;
    expect_wr(16'h0020, 8'hFF);
    bus.mem_ready = 1'b1;
    wait_done(base, "t4_done");
    idle_cycles(3);
    check_val("t4_writes", wr_count - wb, 32'd1);
    check_val("t4_byte_idx", {16'd0, byte_idx}, 32'h0021);
    check_val("t4_pending", exp_q.size(), 32'd0);

    // 5: reset in the middle of a 256-bit run
    wb = wr_count;
    do_start(16'h0000);
    expect_wr(16'h0000, 8'hFF);
    expect_wr(16'h0001, 8'hFF);
    expect_wr(16'h0002, 8'hFF);
    send_token(1'b1, 8'd0);
    waited = 0;
    while (wr_count < wb + 3 && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    check_val("t5_writes_before_rst", wr_count - wb, 32'd3);
    @(posedge clk);
    @(posedge clk);
    #2;
    check_val("t5_pre_rst_wr", {31'd0, bus.mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    check_val("t5_pending", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = done_cnt;
    do_start(16'h0040);
    expect_wr(16'h0040, 8'h0F);
    send_token(1'b0, 8'd4);
    wait_done(base, "t5_done_a");
    send_token(1'b1, 8'd4);
    wait_done(base + 1, "t5_done_b");
    idle_cycles(3);
    check_val("t5_byte_idx", {16'd0, byte_idx}, 32'h0041);
    check_val("t5_pending_after", exp_q.size(), 32'd0);

    // 6: address wrap at 0xFFFF
    base = done_cnt;
    do_start(16'hFFFF);
    expect_wr(16'hFFFF, 8'hFF);
    expect_wr(16'h0000, 8'hFF);
    send_token(1'b1, 8'd16);
    wait_done(base, "t6_done");
    idle_cycles(3);
    check_val("t6_byte_idx", {16'd0, byte_idx}, 32'h0001);
    check_val("t6_bit_idx", {29'd0, bit_idx}, 32'd7);
    check_val("t6_pending", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
